// File: rtl/gat_subgraph_scheduler.sv
// Layer sequencer for the GAT pipeline: waits for BRAM loads, issues subgraph IDs to SPMM
// under an in-flight credit limit, and pulses layer_done_o once every subgraph has retired.
// Define GAT_SCHED_PERF_EN to add the load-wait, layer-length and stall cycle counters.
module gat_subgraph_scheduler #(
  parameter int unsigned NUM_SUBGRAPHS = 2708,
  parameter int unsigned MAX_INFLIGHT  = 4,
  parameter int unsigned SG_ID_W       = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1,
  parameter int unsigned CNT_W         = $clog2(NUM_SUBGRAPHS + 1),
  parameter int unsigned CRD_W         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               h_data_bram_load_done,
  input  logic               h_node_info_bram_load_done,
  input  logic               wgt_bram_load_done,
  input  logic               a_bram_load_done,
  output logic               spmm_vld_o,
  input  logic               spmm_rdy_i,
  output logic [SG_ID_W-1:0] spmm_sg_id_o,
  input  logic               aggr_done_i,
  output logic [CRD_W-1:0]   inflight_o,
  output logic [CNT_W-1:0]   issued_cnt_o,
  output logic [CNT_W-1:0]   retired_cnt_o,
  output logic               busy_o,
  output logic               layer_done_o,
  output logic               err_o
`ifdef GAT_SCHED_PERF_EN
  ,
  output logic [31:0]        load_wait_cyc_o,
  output logic [31:0]        layer_cyc_o,
  output logic [31:0]        stall_cyc_o
`endif
);

  localparam logic [CNT_W-1:0] NUM_SG  = CNT_W'(NUM_SUBGRAPHS);
  localparam logic [CRD_W-1:0] MAX_CRD = CRD_W'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOAD = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               vld_q, vld_d;
  logic [SG_ID_W-1:0] sg_id_q, sg_id_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CRD_W-1:0]   inflight_q, inflight_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic xfer;
  logic all_loaded;
  logic active;

  assign xfer       = vld_q & spmm_rdy_i;
  assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done &
                      wgt_bram_load_done & a_bram_load_done;
  assign active     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) || (state_q == ST_DONE);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vld_q      <= 1'b0;
      sg_id_q    <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      sg_id_q    <= sg_id_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state, credit accounting and output decode
  always_comb begin
    state_d    = state_q;
    sg_id_d    = sg_id_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    // A done with nothing in flight and no same-cycle issue to cover it is a protocol error
    if (active) begin
      if (xfer) begin
        sg_id_d  = sg_id_q + SG_ID_W'(1);
        issued_d = issued_q + CNT_W'(1);
      end
      if (aggr_done_i) begin
        if ((inflight_q == '0) && !xfer) begin
          err_d = 1'b1;
        end else begin
          retired_d = retired_q + CNT_W'(1);
        end
      end
      if (xfer && !aggr_done_i) begin
        inflight_d = inflight_q + CRD_W'(1);
      end else if (!xfer && aggr_done_i && (inflight_q != '0)) begin
        inflight_d = inflight_q - CRD_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (aggr_done_i) err_d = 1'b1;
        if (start_i) begin
          state_d    = ST_WAIT_LOAD;
          sg_id_d    = '0;
          issued_d   = '0;
          retired_d  = '0;
          inflight_d = '0;
        end
      end
      ST_WAIT_LOAD: begin
        if (aggr_done_i) err_d = 1'b1;
        if (all_loaded) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issued_d == NUM_SG) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (retired_d == NUM_SG) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Valid looks at next-cycle counts so a credit-exhausting issue drops it immediately
    vld_d  = (state_d == ST_ISSUE) && (inflight_d < MAX_CRD) && (issued_d < NUM_SG);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign spmm_vld_o    = vld_q;
  assign spmm_sg_id_o  = sg_id_q;
  assign inflight_o    = inflight_q;
  assign issued_cnt_o  = issued_q;
  assign retired_cnt_o = retired_q;
  assign busy_o        = busy_q;
  assign layer_done_o  = done_q;
  assign err_o         = err_q;

`ifdef GAT_SCHED_PERF_EN
  logic [31:0] load_wait_q;
  logic [31:0] layer_q;
  logic [31:0] stall_q;
  logic        first_seen_q;
  logic        start_acc;
  logic        credit_blk;

  assign start_acc  = (state_q == ST_IDLE) && start_i;
  assign credit_blk = (state_q == ST_ISSUE) && !vld_q && (inflight_q == MAX_CRD) &&
                      (issued_q < NUM_SG);

  // Saturating performance counters, cleared when a start is accepted
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      load_wait_q  <= '0;
      layer_q      <= '0;
      stall_q      <= '0;
      first_seen_q <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT_LOAD) && (load_wait_q != '1)) begin
        load_wait_q <= load_wait_q + 32'd1;
      end
      if (xfer) first_seen_q <= 1'b1;
      if (active && (first_seen_q || xfer) && (layer_q != '1)) begin
        layer_q <= layer_q + 32'd1;
      end
      if ((state_q == ST_ISSUE) && ((vld_q && !spmm_rdy_i) || credit_blk) &&
          (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign load_wait_cyc_o = load_wait_q;
  assign layer_cyc_o     = layer_q;
  assign stall_cyc_o     = stall_q;
`endif

endmodule

// File: tb/tb_gat_subgraph_scheduler.sv
// Bench for gat_subgraph_scheduler: directed steps plus randomized layers checked every cycle
// against a count-based model of the issue/retire rules.
module tb_gat_subgraph_scheduler;
  localparam int unsigned NSG  = 5;
  localparam int unsigned MAXI = 2;
  localparam int unsigned IDW  = $clog2(NSG);
  localparam int unsigned CW   = $clog2(NSG + 1);
  localparam int unsigned RW   = $clog2(MAXI + 1);

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ISSUE = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic           h_data_bram_load_done;
  logic           h_node_info_bram_load_done;
  logic           wgt_bram_load_done;
  logic           a_bram_load_done;
  logic           spmm_vld_o;
  logic           spmm_rdy_i;
  logic [IDW-1:0] spmm_sg_id_o;
  logic           aggr_done_i;
  logic [RW-1:0]  inflight_o;
  logic [CW-1:0]  issued_cnt_o;
  logic [CW-1:0]  retired_cnt_o;
  logic           busy_o;
  logic           layer_done_o;
  logic           err_o;
`ifdef GAT_SCHED_PERF_EN
  logic [31:0]    load_wait_cyc_o;
  logic [31:0]    layer_cyc_o;
  logic [31:0]    stall_cyc_o;
`endif

  always #5 clk = ~clk;

  gat_subgraph_scheduler #(
    .NUM_SUBGRAPHS(NSG),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start_i                   (start_i),
    .h_data_bram_load_done     (h_data_bram_load_done),
    .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .wgt_bram_load_done        (wgt_bram_load_done),
    .a_bram_load_done          (a_bram_load_done),
    .spmm_vld_o                (spmm_vld_o),
    .spmm_rdy_i                (spmm_rdy_i),
    .spmm_sg_id_o              (spmm_sg_id_o),
    .aggr_done_i               (aggr_done_i),
    .inflight_o                (inflight_o),
    .issued_cnt_o              (issued_cnt_o),
    .retired_cnt_o             (retired_cnt_o),
    .busy_o                    (busy_o),
    .layer_done_o              (layer_done_o),
    .err_o                     (err_o)
`ifdef GAT_SCHED_PERF_EN
    ,
    .load_wait_cyc_o           (load_wait_cyc_o),
    .layer_cyc_o               (layer_cyc_o),
    .stall_cyc_o               (stall_cyc_o)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: layer phase plus issued/retired totals; in-flight is their difference
  int ph = P_IDLE;
  int m_issued = 0;
  int m_retired = 0;
  bit m_err = 1'b0;
  bit m_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_issued = 0; m_retired = 0; m_err = 1'b0; m_vld = 1'b0;
  endtask

  task automatic model_step(input bit st, input logic [3:0] ld, input bit rdy, input bit ag);
    bit xf;
    xf = m_vld && rdy;
    if (ph == P_IDLE) begin
      if (ag) m_err = 1'b1;
      if (st) begin ph = P_WAIT; m_issued = 0; m_retired = 0; end
    end else if (ph == P_WAIT) begin
      if (ag) m_err = 1'b1;
      if (ld == 4'hF) ph = P_ISSUE;
    end else begin
      if (ag) begin
        if ((m_issued - m_retired) == 0 && !xf) m_err = 1'b1;
        else m_retired++;
      end
      if (xf) m_issued++;
      if (ph == P_DONE) ph = P_IDLE;
      else if (ph == P_ISSUE && m_issued == NSG) ph = P_DRAIN;
      else if (ph == P_DRAIN && m_retired == NSG) ph = P_DONE;
    end
    m_vld = (ph == P_ISSUE) && ((m_issued - m_retired) < MAXI) && (m_issued < NSG);
  endtask

  task automatic check_all();
    chk("vld",        32'(spmm_vld_o),    32'(m_vld));
    chk("sg_id",      32'(spmm_sg_id_o),  32'(m_issued % (1 << IDW)));
    chk("inflight",   32'(inflight_o),    32'(m_issued - m_retired));
    chk("issued",     32'(issued_cnt_o),  32'(m_issued));
    chk("retired",    32'(retired_cnt_o), 32'(m_retired));
    chk("busy",       32'(busy_o),        32'(ph != P_IDLE));
    chk("layer_done", 32'(layer_done_o),  32'(ph == P_DONE));
    chk("err",        32'(err_o),         32'(m_err));
  endtask

  // One clock: drive inputs, advance the model, sample 1ns after the edge
  task automatic cyc(input bit st, input logic [3:0] ld, input bit rdy, input bit ag);
    start_i = st;
    h_data_bram_load_done      = ld[0];
    h_node_info_bram_load_done = ld[1];
    wgt_bram_load_done         = ld[2];
    a_bram_load_done           = ld[3];
    spmm_rdy_i  = rdy;
    aggr_done_i = ag;
    if (!rst_n) model_reset();
    else model_step(st, ld, rdy, ag);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic random_layer();
    int n;
    logic [3:0] ld;
    bit rdy, ag, st;
    n = 0;
    cyc(1'b1, 4'h0, 1'b0, 1'b0);
    while (ph != P_IDLE && n < 400) begin
      ld  = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) < 7);
      ag  = ((m_issued - m_retired) > 0) ? ($urandom_range(0, 9) < 4) : 1'b0;
      st  = ($urandom_range(0, 9) == 0);
      cyc(st, ld, rdy, ag);
      n++;
    end
    if (n >= 400) chk("layer_timeout", 32'(n), 32'(0));
    chk("layer_retired_total", 32'(retired_cnt_o), 32'(NSG));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start_i = 1'b0; spmm_rdy_i = 1'b0; aggr_done_i = 1'b0;
    h_data_bram_load_done = 1'b0; h_node_info_bram_load_done = 1'b0;
    wgt_bram_load_done = 1'b0; a_bram_load_done = 1'b0;

    // Reset, then a start with no loads: busy but never valid
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'($urandom_range(0, 14)), 1'b1, 1'b0);
    chk("wait_busy", 32'(busy_o), 32'd1);

    // Credit exhaustion after IDs 0,1
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF, 1'b1, 1'b0);
    chk("credit_inflight", 32'(inflight_o), 32'd2);
    chk("credit_vld_low", 32'(spmm_vld_o), 32'd0);
    cyc(1'b0, 4'hF, 1'b1, 1'b1);
    chk("credit_free_vld", 32'(spmm_vld_o), 32'd1);
    cyc(1'b0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 4'hF, 1'b1, 1'b1);
    // Hold ID 3 under backpressure
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'hF, 1'b0, 1'b0);
    chk("stall_vld", 32'(spmm_vld_o), 32'd1);
    chk("stall_id", 32'(spmm_sg_id_o), 32'd3);
    // Issue and retire in the same cycle at inflight=1
    cyc(1'b0, 4'hF, 1'b1, 1'b1);
    chk("both_inflight", 32'(inflight_o), 32'd1);
    chk("both_retired", 32'(retired_cnt_o), 32'd3);
    cyc(1'b0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 4'hF, 1'b0, 1'b1);
    cyc(1'b0, 4'hF, 1'b0, 1'b1);
    chk("layer_done_pulse", 32'(layer_done_o), 32'd1);
    cyc(1'b0, 4'hF, 1'b0, 1'b0);
    chk("idle_issued_hold", 32'(issued_cnt_o), 32'd5);
    chk("idle_retired_hold", 32'(retired_cnt_o), 32'd5);
    // Done in IDLE is an error, and it sticks
    cyc(1'b0, 4'hF, 1'b0, 1'b1);
    chk("err_idle", 32'(err_o), 32'd1);
    repeat (3) cyc(1'b0, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    repeat (4) random_layer();

    // Reset in DRAIN with two in flight
    cyc(1'b1, 4'hF, 1'b1, 1'b0);
    n = 0;
    while (ph != P_DRAIN && n < 50) begin
      cyc(1'b0, 4'hF, 1'b1, ((m_issued - m_retired) == MAXI) && (m_issued < NSG));
      n++;
    end
    chk("drain_inflight", 32'(inflight_o), 32'd2);
    rst_n = 1'b0;
    cyc(1'b0, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("drain_reset_busy", 32'(busy_o), 32'd0);

    random_layer();

    // Done at inflight=0 while in ISSUE with no issue that cycle
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    cyc(1'b0, 4'hF, 1'b0, 1'b0);
    cyc(1'b0, 4'hF, 1'b0, 1'b1);
    chk("err_issue_empty", 32'(err_o), 32'd1);
    chk("err_retired_hold", 32'(retired_cnt_o), 32'd0);
    cyc(1'b0, 4'hF, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 4'hF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gat_subgraph_scheduler.md
Name: gat_subgraph_scheduler

Overview:
- Layer-level sequencer for the GAT pipeline (SPMM -> DMVM -> softmax -> aggregator).
- Waits until all four input BRAMs (H data, node info, weight, a) report load done, then issues subgraph IDs to SPMM in order.
- Bounds the number of subgraphs in flight with a credit counter that is replenished by aggregator completions.
- Raises a layer-done pulse after the last subgraph retires.

Parameters:
- NUM_SUBGRAPHS, 2708: subgraphs per layer. Must be >= 1.
- MAX_INFLIGHT, 4: maximum number of issued-but-not-retired subgraphs. Must be >= 1.
- SG_ID_W, $clog2(NUM_SUBGRAPHS): width of a subgraph ID.
- CNT_W, $clog2(NUM_SUBGRAPHS+1): width of the issue and retire counters.
- CRD_W, $clog2(MAX_INFLIGHT+1): width of the in-flight counter.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  single-cycle request to start a layer.
- h_data_bram_load_done  in  1  level; H data BRAM loaded.
- h_node_info_bram_load_done  in  1  level; node-info BRAM loaded.
- wgt_bram_load_done  in  1  level; weight BRAM loaded.
- a_bram_load_done  in  1  level; a-vector BRAM loaded.
- spmm_vld_o  out  1  subgraph issue valid.
- spmm_rdy_i  in  1  SPMM accepts the issue.
- spmm_sg_id_o  out  SG_ID_W  ID of the subgraph being issued.
- aggr_done_i  in  1  one-cycle pulse per retired subgraph.
- inflight_o  out  CRD_W  current in-flight count.
- issued_cnt_o  out  CNT_W  subgraphs issued so far this layer.
- retired_cnt_o  out  CNT_W  subgraphs retired so far this layer.
- busy_o  out  1  high in any state other than IDLE.
- layer_done_o  out  1  one-cycle pulse on completion of a layer.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset:
  - Applies only on a rising clk edge with rst_n=0.
  - All outputs go to 0 and the FSM goes to IDLE.
  - A mid-layer reset abandons the layer; in-flight work is not tracked afterwards.
- FSM states and transitions:
  - IDLE -> WAIT_LOAD when start_i=1.
  - WAIT_LOAD -> ISSUE when the AND of all four load_done inputs is 1. They are sampled each cycle.
  - ISSUE -> DRAIN when issued_cnt reaches NUM_SUBGRAPHS.
  - DRAIN -> DONE when retired_cnt reaches NUM_SUBGRAPHS.
  - DONE lasts one cycle with layer_done_o=1, then -> IDLE.
  - start_i is ignored outside IDLE.
- Issue handshake:
  - spmm_vld_o is registered. It is 1 in ISSUE while inflight < MAX_INFLIGHT and issued_cnt < NUM_SUBGRAPHS.
  - A transfer occurs on a cycle with spmm_vld_o && spmm_rdy_i.
  - On a transfer, spmm_sg_id_o and issued_cnt increment on the next edge.
  - spmm_sg_id_o holds stable while spmm_vld_o=1 && spmm_rdy_i=0.
  - spmm_vld_o never drops without a transfer, except on reset.
  - The first issue has spmm_sg_id_o=0. The ID restarts from 0 at each new layer.
- Latency:
  - WAIT_LOAD sees all load_done = 1 at edge N; spmm_vld_o=1 from N+1.
  - Back-to-back transfers give one issue per cycle.
- Credits (inflight counter):
  - Transfer only: inflight +1.
  - aggr_done_i only: inflight -1, retired_cnt +1.
  - Both in the same cycle: inflight unchanged, retired_cnt +1.
  - At inflight = MAX_INFLIGHT, spmm_vld_o deasserts on the edge after the credit-exhausting transfer. No overshoot is allowed.
  - A done that frees a credit allows vld again on the following edge.
- Errors:
  - aggr_done_i with inflight=0 and no simultaneous transfer: err_o=1, counters unchanged.
  - aggr_done_i in IDLE or WAIT_LOAD: err_o=1.
  - err_o clears only on reset.
- Counters are captured at start_i and cleared on IDLE->WAIT_LOAD. They hold their final values in IDLE after DONE.

Optional Feature:
- Macro: GAT_SCHED_PERF_EN.
- When defined, add outputs:
  - load_wait_cyc_o (32 bit): cycles spent in WAIT_LOAD.
  - layer_cyc_o (32 bit): cycles from the first issue to layer_done_o inclusive.
  - stall_cyc_o (32 bit): ISSUE cycles with spmm_vld_o && !spmm_rdy_i, plus ISSUE cycles blocked by credits.
  - All three clear on start acceptance and saturate at 2^32-1.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset check -> after rst_n=0 for 2 cycles, every output is 0 and busy_o=0. A start_i pulse with all load_done=0 -> busy_o=1 and spmm_vld_o stays 0 for 20 cycles.
- NUM_SUBGRAPHS=5, MAX_INFLIGHT=2, spmm_rdy_i=1, no aggr_done -> exactly IDs 0,1 issued, vld drops, inflight_o=2. Two aggr_done pulses -> IDs 2,3 follow.
- Full layer (5 subgraphs) with aggr_done 3 cycles after each issue -> issued 0..4 in order, retired_cnt_o=5, a single layer_done_o pulse, then IDLE with counters holding 5/5.
- spmm_rdy_i low for 4 cycles during ID 2 -> spmm_vld_o=1 and spmm_sg_id_o=2 held stable; the transfer completes when rdy rises and stall_cyc_o=4 (with GAT_SCHED_PERF_EN).
- Transfer and aggr_done_i in the same cycle at inflight=1 -> inflight stays 1, retired +1. aggr_done_i at inflight=0 -> err_o=1 and sticky.
- Reset asserted in DRAIN with inflight=2 -> next cycle all outputs 0. A new start_i runs a clean layer starting at ID 0.
